// File: rtl/w25q_pkg.sv
// Shared definitions for the W25Q32JV burst read sequencer:
// FSM state encoding, flash address mask, FIFO entry layout and the
// address-step helper used when advancing through a burst.
package w25q_pkg;

  // 4 MB part: byte addresses live in the low 22 bits
  localparam logic [23:0] W25Q_ADDR_MASK = 24'h3FFFFF;

  // One fast-read transaction returns a 16-bit word (two bytes)
  localparam int WORD_W  = 16;
  localparam int ENTRY_W = WORD_W + 1;

  // Sequencer states (IDLE must stay all-zero so reset shows state 0)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Output FIFO entry: last flag above the data word
  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } entry_t;

  // Step to the next word address, wrapping at the top of the device
  function automatic logic [23:0] next_addr(input logic [23:0] addr);
    return (addr + 24'd2) & W25Q_ADDR_MASK;
  endfunction

endpackage

// File: rtl/w25q_rdseq_fifo.sv
// Small synchronous FIFO holding {last, data} entries for the read
// sequencer. DEPTH must be a power of two so the pointers wrap naturally.
// The head entry is presented combinationally; count is exposed so the
// sequencer can reserve a slot before launching a transaction.
module w25q_rdseq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 17,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             full;

  assign full       = (count == DEPTH_C);
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
  assign do_pop     = pop & head_valid;
  // A pop in the same cycle frees the slot, so push is legal even when full
  assign do_push    = push & (~full | do_pop);

  // Storage and pointers; storage is cleared so outputs read 0 after reset
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/w25q32jv_read_seq.sv
// Burst read sequencer in front of the W25Q32JV fast-read engine.
// Takes one {addr, len} request, launches one fast-read per 16-bit word
// at +2 byte steps, and streams captured words out through a small FIFO.
// Optional done watchdog: define W25Q_RDSEQ_TIMEOUT_EN.
//
// Handshakes: every valid/ready pair transfers on a clock edge where both
// are high; valid never depends on ready. req_ready is high only in IDLE.
// dout_valid/dout_data/dout_last describe the FIFO head and stay stable
// until popped.
module w25q32jv_read_seq
  import w25q_pkg::*;
#(
  parameter int LEN_W          = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             fastread_start,
  output logic [23:0]      fastread_addr,
  input  logic             fastread_done,
  input  logic [7:0]       data_out_1,
  input  logic [7:0]       data_out_2,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [15:0]      dout_data,
  output logic             dout_last,
  output logic             busy,
  output logic             seq_done,
  output logic             timeout_err,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Gap counter sized so GAP_CYCLES = 0 still gives a legal width
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]       state;
  logic [LEN_W-1:0] remaining;
  logic [GAP_W-1:0] gap_cnt;
  logic             done_q;
  logic             done_rise;
  logic             last_word;
  logic             push;
  entry_t           push_entry;
  entry_t           head_entry;
  logic [CNT_W-1:0] fifo_count;

`ifdef W25Q_RDSEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_cnt;
`endif

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;
  assign done_rise  = fastread_done & ~done_q;
  assign last_word  = (remaining == LEN_W'(1));

  // The FIFO slot was reserved in ISSUE, so a capture can always be pushed
  assign push            = (state == ST_WAIT) & done_rise;
  assign push_entry.last = last_word;
  assign push_entry.data = {data_out_1, data_out_2};

  assign dout_data = head_entry.data;
  assign dout_last = head_entry.last;

  // Registered copy of done for rising-edge detection
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) done_q <= 1'b0;
    else        done_q <= fastread_done;
  end

  // Burst control FSM: accept, launch, capture, enforce inter-read gap
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state          <= ST_IDLE;
      remaining      <= '0;
      gap_cnt        <= '0;
      fastread_addr  <= '0;
      fastread_start <= 1'b0;
      seq_done       <= 1'b0;
`ifdef W25Q_RDSEQ_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      fastread_start <= 1'b0;
      seq_done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            fastread_addr <= req_addr;
            remaining     <= req_len;
            if (req_len == '0) seq_done <= 1'b1;
            else               state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Launch only while a FIFO slot is free for the result
          if (fifo_count < DEPTH_C) begin
            fastread_start <= 1'b1;
            state          <= ST_WAIT;
`ifdef W25Q_RDSEQ_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (done_rise) begin
            remaining     <= remaining - 1'b1;
            fastread_addr <= next_addr(fastread_addr);
            if (last_word) begin
              seq_done <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end
`ifdef W25Q_RDSEQ_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            // Engine never answered: abandon the rest of the burst
            remaining <= '0;
            seq_done  <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_GAP: begin
          // Minimum idle time, and done must have dropped before relaunch
          if (gap_cnt < GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
          else if (!fastread_done) state <= ST_ISSUE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef W25Q_RDSEQ_TIMEOUT_EN
  // Sticky watchdog flag, cleared when a new request is accepted
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      timeout_err <= 1'b0;
    end else if (state == ST_IDLE && req_valid) begin
      timeout_err <= 1'b0;
    end else if (state == ST_WAIT && !done_rise && wait_cnt == TO_LAST) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  w25q_rdseq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .arstn      (arstn),
    .push       (push),
    .push_data  (push_entry),
    .pop        (dout_valid & dout_ready),
    .head_data  (head_entry),
    .head_valid (dout_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_w25q32jv_read_seq.sv
// Bench for w25q32jv_read_seq (default build, watchdog macro undefined).
// A behavioural fast-read engine answers each start with bytes equal to
// the low address byte of each location; expected words and addresses
// are hand-computed constants pushed to queues, and monitors pop/compare.
module tb_w25q32jv_read_seq;

  logic        clk;
  logic        arstn;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [15:0] req_len;
  logic        fastread_start;
  logic [23:0] fastread_addr;
  logic        fastread_done;
  logic [7:0]  data_out_1;
  logic [7:0]  data_out_2;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] dout_data;
  logic        dout_last;
  logic        busy;
  logic        seq_done;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;
  int start_cnt;
  int seq_cnt;
  bit chk_lat;

  logic [16:0] exp_q[$];
  logic [23:0] exp_addr_q[$];

  w25q32jv_read_seq dut (
    .clk            (clk),
    .arstn          (arstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .fastread_start (fastread_start),
    .fastread_addr  (fastread_addr),
    .fastread_done  (fastread_done),
    .data_out_1     (data_out_1),
    .data_out_2     (data_out_2),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .dout_data      (dout_data),
    .dout_last      (dout_last),
    .busy           (busy),
    .seq_done       (seq_done),
    .timeout_err    (timeout_err),
    .dbg_state      (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Fast-read engine model: 3 cycles after start raise done for 3 cycles
  initial begin
    logic [23:0] eng_addr;
    logic [23:0] eng_addr1;
    fastread_done = 1'b0;
    data_out_1    = 8'h00;
    data_out_2    = 8'h00;
    forever begin
      @(negedge clk);
      if (arstn && fastread_start) begin
        eng_addr = fastread_addr;
        repeat (3) @(negedge clk);
        eng_addr1     = eng_addr + 24'd1;
        data_out_1    = eng_addr[7:0];
        data_out_2    = eng_addr1[7:0];
        fastread_done = 1'b1;
        @(negedge clk);
        if (chk_lat) check("dout_latency_valid", {31'd0, dout_valid}, 32'd1);
        repeat (2) @(negedge clk);
        fastread_done = 1'b0;
      end
    end
  end

  // Scoreboard: output words
  always @(negedge clk) begin
    if (arstn && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dout_unexpected: got 0x%0h expected no word", {dout_last, dout_data});
      end else begin
        check("dout_word", {15'd0, dout_last, dout_data}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  // Scoreboard: launch addresses
  always @(negedge clk) begin
    if (arstn && fastread_start) begin
      start_cnt++;
      if (exp_addr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL start_unexpected: got addr 0x%0h expected no start", fastread_addr);
      end else begin
        check("fastread_addr", {8'd0, fastread_addr}, {8'd0, exp_addr_q.pop_front()});
      end
    end
  end

  always @(negedge clk) if (arstn && seq_done) seq_cnt++;

  task automatic send_req(input logic [23:0] a, input logic [15:0] l);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_seen", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_seq(input int base, input int budget);
    int n;
    n = 0;
    while (seq_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("seq_done_seen", (seq_cnt != base) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Main stimulus
  initial begin
    int base_s;
    int base_d;
    int busy_seen;
    vectors     = 0;
    miscompares = 0;
    start_cnt   = 0;
    seq_cnt     = 0;
    chk_lat     = 1'b0;
    arstn       = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    dout_ready  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready",   {31'd0, req_ready}, 32'd1);
    check("rst_busy",        {31'd0, busy}, 32'd0);
    check("rst_start",       {31'd0, fastread_start}, 32'd0);
    check("rst_addr",        {8'd0, fastread_addr}, 32'd0);
    check("rst_dout_valid",  {31'd0, dout_valid}, 32'd0);
    check("rst_seq_done",    {31'd0, seq_done}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    arstn = 1'b1;
    repeat (2) @(negedge clk);

    // Burst 0x10 x3, consumer always ready
    dout_ready = 1'b1;
    chk_lat    = 1'b1;
    exp_addr_q = '{24'h000010, 24'h000012, 24'h000014};
    exp_q      = '{17'h01011, 17'h01213, 17'h11415};
    base_s = start_cnt;
    base_d = seq_cnt;
    send_req(24'h000010, 16'd3);
    wait_seq(base_d, 300);
    repeat (5) @(negedge clk);
    chk_lat = 1'b0;
    check("b1_starts",   start_cnt - base_s, 32'd3);
    check("b1_words_left", exp_q.size(), 32'd0);
    check("b1_idle",     {31'd0, busy}, 32'd0);

    // Wrap at top of device
    exp_addr_q = '{24'h3FFFFE, 24'h000000};
    exp_q      = '{17'h0FEFF, 17'h10001};
    base_s = start_cnt;
    base_d = seq_cnt;
    send_req(24'h3FFFFE, 16'd2);
    wait_seq(base_d, 300);
    repeat (5) @(negedge clk);
    check("b2_starts",     start_cnt - base_s, 32'd2);
    check("b2_words_left", exp_q.size(), 32'd0);

    // Backpressure: 8 words with consumer stalled
    dout_ready = 1'b0;
    exp_addr_q = '{24'h000100, 24'h000102, 24'h000104, 24'h000106,
                   24'h000108, 24'h00010A, 24'h00010C, 24'h00010E};
    exp_q      = '{17'h00001, 17'h00203, 17'h00405, 17'h00607,
                   17'h00809, 17'h00A0B, 17'h00C0D, 17'h10E0F};
    base_s = start_cnt;
    base_d = seq_cnt;
    send_req(24'h000100, 16'd8);
    repeat (150) @(negedge clk);
    check("b3_stall_starts", start_cnt - base_s, 32'd4);
    check("b3_stall_state",  {30'd0, dbg_state}, 32'd1);
    check("b3_stall_busy",   {31'd0, busy}, 32'd1);
    check("b3_stall_valid",  {31'd0, dout_valid}, 32'd1);
    dout_ready = 1'b1;
    wait_seq(base_d, 500);
    repeat (5) @(negedge clk);
    check("b3_starts",     start_cnt - base_s, 32'd8);
    check("b3_words_left", exp_q.size(), 32'd0);

    // Zero-length request
    base_s = start_cnt;
    busy_seen = 0;
    send_req(24'h000040, 16'd0);
    @(negedge clk);
    check("z_seq_done_pulse", {31'd0, seq_done}, 32'd1);
    if (busy) busy_seen++;
    @(negedge clk);
    check("z_seq_done_clear", {31'd0, seq_done}, 32'd0);
    repeat (5) begin
      if (busy) busy_seen++;
      @(negedge clk);
    end
    check("z_busy", busy_seen, 32'd0);
    check("z_starts", start_cnt - base_s, 32'd0);

    // Reset during WAIT of the second word
    exp_addr_q = '{24'h000200, 24'h000202};
    exp_q      = '{17'h00001};
    base_s = start_cnt;
    send_req(24'h000200, 16'd3);
    begin
      int n;
      n = 0;
      while (start_cnt - base_s < 2 && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    check("r_second_start", start_cnt - base_s, 32'd2);
    check("r_in_wait", {30'd0, dbg_state}, 32'd2);
    arstn = 1'b0;
    #1;
    check("r_req_ready",  {31'd0, req_ready}, 32'd1);
    check("r_busy",       {31'd0, busy}, 32'd0);
    check("r_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("r_addr",       {8'd0, fastread_addr}, 32'd0);
    check("r_start",      {31'd0, fastread_start}, 32'd0);
    check("r_dout_data",  {15'd0, dout_last, dout_data}, 32'd0);
    check("r_words_left", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    repeat (20) @(negedge clk);
    check("r_stay_idle", {30'd0, dbg_state}, 32'd0);
    check("r_no_output", {31'd0, dout_valid}, 32'd0);
    check("r_addr_q_left", exp_addr_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
